// File: rtl/mod_n_seq_ctrl.sv
// Run-time controller for a modulo-N counter: programmable modulus and repeat
// count, start/pause/stop sequencing, and per-wrap / end-of-run strobes.
module mod_n_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int REPW    = 8,
    parameter int DEF_MOD = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [WIDTH-1:0] cfg_mod_i,
    input  logic [REPW-1:0]  cfg_reps_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [REPW-1:0]  reps_left_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mod_q;
    logic [REPW-1:0]  reps_q;
    logic [WIDTH-1:0] count_q;
    logic [REPW-1:0]  reps_left_q;
    logic             wrap_q;
    logic             done_q;

    logic [WIDTH-1:0] last_cnt;
    logic             at_last;
    logic             cfg_fire;
    logic [REPW-1:0]  start_reps;

    // A stored modulus of 0 yields an all-ones terminal count, i.e. M = 2^WIDTH.
    assign last_cnt   = mod_q - WIDTH'(1);
    assign at_last    = (count_q == last_cnt);
    assign cfg_fire   = cfg_valid_i && (state_q == IDLE);
    assign start_reps = cfg_fire ? cfg_reps_i : reps_q;

    // NOTE: non-blocking assignments so every branch below sees pre-edge register values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mod_q       <= WIDTH'(DEF_MOD);
            reps_q      <= '0;
            count_q     <= '0;
            reps_left_q <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (cfg_fire) begin
                        mod_q  <= cfg_mod_i;
                        reps_q <= cfg_reps_i;
                    end
                    if (start_i) begin
                        state_q     <= RUN;
                        reps_left_q <= start_reps;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        reps_left_q <= '0;
                    end else if (pause_i) begin
                        state_q <= PAUSE;
                    end else if (at_last) begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                        if (reps_q != '0) begin
                            reps_left_q <= reps_left_q - REPW'(1);
                            if (reps_left_q == REPW'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                PAUSE: begin
                    if (stop_i) begin
                        state_q     <= IDLE;
                        count_q     <= '0;
                        reps_left_q <= '0;
                    end else if (!pause_i) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == RUN) || (state_q == PAUSE);
    assign count_o     = count_q;
    assign wrap_o      = wrap_q;
    assign done_o      = done_q;
    assign reps_left_o = reps_left_q;

endmodule

// File: tb/tb_mod_n_seq_ctrl.sv
// Self-checking bench for mod_n_seq_ctrl: vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_mod_n_seq_ctrl;

    logic       clk;
    logic       rst, cfg_valid, start, pause, stop;
    logic [3:0] cfg_mod;
    logic [7:0] cfg_reps;
    logic       cfg_ready, wrap, done, busy;
    logic [3:0] count;
    logic [7:0] reps_left;

    int n_checks = 0;
    int n_fail   = 0;

    mod_n_seq_ctrl #(.WIDTH(4), .REPW(8), .DEF_MOD(10)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_mod_i   (cfg_mod),
        .cfg_reps_i  (cfg_reps),
        .start_i     (start),
        .pause_i     (pause),
        .stop_i      (stop),
        .count_o     (count),
        .wrap_o      (wrap),
        .done_o      (done),
        .busy_o      (busy),
        .reps_left_o (reps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a run is described by the number of counted edges n,
    // from which count, wrap and remaining repeats follow arithmetically.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_e;
    mmode_e m_mode = M_IDLE;
    int m_mod = 10, m_reps = 0, m_n = 0, m_mrun = 1, m_rrun = 0;
    bit m_adv = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = M_IDLE; m_mod = 10; m_reps = 0; m_n = 0; m_adv = 0;
        end else begin
            m_adv = 0;
            case (m_mode)
                M_IDLE: begin
                    if (cfg_valid) begin
                        m_mod  = (cfg_mod == 0) ? 16 : int'(cfg_mod);
                        m_reps = int'(cfg_reps);
                    end
                    if (start) begin
                        m_mode = M_RUN; m_n = 0; m_mrun = m_mod; m_rrun = m_reps;
                    end
                end
                M_RUN: begin
                    if (stop) m_mode = M_IDLE;
                    else if (pause) m_mode = M_PAUSE;
                    else begin
                        m_n++;
                        m_adv = 1;
                        if (m_rrun != 0 && m_n == m_mrun * m_rrun) m_mode = M_DONE;
                    end
                end
                M_PAUSE: begin
                    if (stop) m_mode = M_IDLE;
                    else if (!pause) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic model_check(input string tag);
        int e_cnt, e_wrap, e_done, e_busy, e_rdy, e_rl;
        e_cnt = 0; e_wrap = 0; e_done = 0; e_busy = 0; e_rdy = 0; e_rl = 0;
        case (m_mode)
            M_IDLE: e_rdy = 1;
            M_RUN, M_PAUSE: begin
                e_cnt  = m_n % m_mrun;
                e_wrap = (m_mode == M_RUN && m_adv && (m_n % m_mrun) == 0) ? 1 : 0;
                e_busy = 1;
                e_rl   = (m_rrun != 0) ? m_rrun - m_n / m_mrun : 0;
            end
            default: begin e_wrap = 1; e_done = 1; end
        endcase
        check({tag, ".count"},     int'(count),     e_cnt);
        check({tag, ".wrap"},      int'(wrap),      e_wrap);
        check({tag, ".done"},      int'(done),      e_done);
        check({tag, ".busy"},      int'(busy),      e_busy);
        check({tag, ".cfg_ready"}, int'(cfg_ready), e_rdy);
        check({tag, ".reps_left"}, int'(reps_left), e_rl);
    endtask

    // One clock edge: inputs already applied are sampled, outputs checked 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        model_check(tag);
    endtask

    task automatic clear_inputs();
        rst = 0; cfg_valid = 0; cfg_mod = 0; cfg_reps = 0; start = 0; pause = 0; stop = 0;
    endtask

    typedef struct {
        logic       rst, cv;
        logic [3:0] cm;
        logic [7:0] cr;
        logic       st, pa, sp;
        int         e_cnt, e_wrap, e_done, e_busy, e_rdy, e_rl;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic cv, input logic [3:0] cm, input logic [7:0] cr,
                       input logic st, input logic pa, input logic sp,
                       input int c, input int w, input int d, input int b, input int rd, input int rl);
        vec_t v;
        v.rst = r; v.cv = cv; v.cm = cm; v.cr = cr; v.st = st; v.pa = pa; v.sp = sp;
        v.e_cnt = c; v.e_wrap = w; v.e_done = d; v.e_busy = b; v.e_rdy = rd; v.e_rl = rl;
        tbl.push_back(v);
    endtask

    initial begin
        clear_inputs();
        rst = 1;

        // rst cv cm cr st pa sp | cnt wrap done busy rdy reps_left
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 1, 3, 2, 1, 0, 0,   0, 0, 0, 1, 0, 2);
        add(0, 1, 7, 5, 0, 0, 0,   1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; cfg_valid = tbl[i].cv; cfg_mod = tbl[i].cm; cfg_reps = tbl[i].cr;
            start = tbl[i].st; pause = tbl[i].pa; stop = tbl[i].sp;
            step($sformatf("tbl%0d_model", i));
            check($sformatf("tbl%0d.count", i),     int'(count),     tbl[i].e_cnt);
            check($sformatf("tbl%0d.wrap", i),      int'(wrap),      tbl[i].e_wrap);
            check($sformatf("tbl%0d.done", i),      int'(done),      tbl[i].e_done);
            check($sformatf("tbl%0d.busy", i),      int'(busy),      tbl[i].e_busy);
            check($sformatf("tbl%0d.cfg_ready", i), int'(cfg_ready), tbl[i].e_rdy);
            check($sformatf("tbl%0d.reps_left", i), int'(reps_left), tbl[i].e_rl);
        end
        clear_inputs();

        // Defaults after reset: continuous mod-10 run
        rst = 1; step("rst_a"); step("rst_b"); rst = 0;
        start = 1; step("def_start"); start = 0;
        check("def_start_count", int'(count), 0);
        check("def_start_busy", int'(busy), 1);
        for (int i = 1; i <= 20; i++) begin
            step("def_run");
            check("def_count", int'(count), i % 10);
            check("def_wrap", int'(wrap), (i % 10 == 0) ? 1 : 0);
            check("def_done", int'(done), 0);
            check("def_reps_left", int'(reps_left), 0);
        end

        // Pause at 4 for three cycles, resume, stop at 7
        repeat (4) step("pz_pre");
        check("pz_at4", int'(count), 4);
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            step("pz_hold");
            check("pz_hold_count", int'(count), 4);
            check("pz_hold_busy", int'(busy), 1);
            check("pz_hold_wrap", int'(wrap), 0);
        end
        pause = 0;
        step("pz_resume"); check("pz_resume_count", int'(count), 4);
        step("pz_next");   check("pz_next_count", int'(count), 5);
        repeat (2) step("pz_to7");
        check("pz_at7", int'(count), 7);
        stop = 1; step("stop"); stop = 0;
        check("stop_count", int'(count), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);

        // Config stalled during a run, accepted once idle
        start = 1; step("hs_start"); start = 0;
        repeat (2) step("hs_run");
        cfg_valid = 1; cfg_mod = 3; cfg_reps = 0;
        step("hs_stall0"); check("hs_ready_run", int'(cfg_ready), 0);
        repeat (6) step("hs_stall");
        check("hs_count9", int'(count), 9);
        step("hs_wrap10");
        check("hs_old_mod_wrap", int'(wrap), 1);
        stop = 1; step("hs_stop"); stop = 0;
        check("hs_ready_idle", int'(cfg_ready), 1);
        step("hs_accept");
        cfg_valid = 0; start = 1; step("hs_new_start"); start = 0;
        for (int i = 1; i <= 4; i++) begin
            step("hs_new_run");
            check("hs_mod3_count", int'(count), i % 3);
            check("hs_mod3_wrap", int'(wrap), (i % 3 == 0) ? 1 : 0);
        end
        stop = 1; step("hs_stop2"); stop = 0;

        // M = 1
        cfg_valid = 1; cfg_mod = 1; cfg_reps = 0; step("m1_cfg"); cfg_valid = 0;
        start = 1; step("m1_start"); start = 0;
        for (int i = 0; i < 5; i++) begin
            step("m1_run");
            check("m1_count", int'(count), 0);
            check("m1_wrap", int'(wrap), 1);
            check("m1_busy", int'(busy), 1);
        end
        stop = 1; step("m1_stop"); stop = 0;

        // M = 2^WIDTH, config and start on the same edge
        cfg_valid = 1; cfg_mod = 0; cfg_reps = 0; start = 1; step("m16_start");
        cfg_valid = 0; start = 0;
        for (int i = 1; i <= 17; i++) begin
            step("m16_run");
            check("m16_count", int'(count), i % 16);
            check("m16_wrap", int'(wrap), (i % 16 == 0) ? 1 : 0);
        end
        stop = 1; step("m16_stop"); stop = 0;

        // Finite run M=5, R=3
        cfg_valid = 1; cfg_mod = 5; cfg_reps = 3; start = 1; step("fin_start");
        cfg_valid = 0; start = 0;
        check("fin_start_rl", int'(reps_left), 3);
        for (int i = 1; i <= 15; i++) begin
            step("fin_run");
            if (i == 15) begin
                check("fin_done", int'(done), 1);
                check("fin_done_wrap", int'(wrap), 1);
                check("fin_done_count", int'(count), 0);
                check("fin_done_rl", int'(reps_left), 0);
                check("fin_done_busy", int'(busy), 0);
            end else begin
                check("fin_count", int'(count), i % 5);
                check("fin_wrap", int'(wrap), (i % 5 == 0) ? 1 : 0);
                check("fin_rl", int'(reps_left), 3 - i / 5);
                check("fin_nodone", int'(done), 0);
            end
        end
        step("fin_idle");
        check("fin_idle_busy", int'(busy), 0);
        check("fin_idle_ready", int'(cfg_ready), 1);
        check("fin_idle_done", int'(done), 0);

        // Reset mid-run restores the default modulus
        cfg_valid = 1; cfg_mod = 10; cfg_reps = 3; start = 1; step("mr_start");
        cfg_valid = 0; start = 0;
        repeat (16) step("mr_run");
        check("mr_count6", int'(count), 6);
        check("mr_rl2", int'(reps_left), 2);
        rst = 1; step("mr_rst"); rst = 0;
        check("mr_rst_count", int'(count), 0);
        check("mr_rst_rl", int'(reps_left), 0);
        check("mr_rst_busy", int'(busy), 0);
        check("mr_rst_ready", int'(cfg_ready), 1);
        start = 1; step("mr_restart"); start = 0;
        repeat (10) step("mr_run2");
        check("mr_defmod_wrap", int'(wrap), 1);
        check("mr_defmod_count", int'(count), 0);
        check("mr_defmod_rl", int'(reps_left), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            cfg_valid = ($urandom_range(3) == 0);
            cfg_mod   = 4'($urandom);
            cfg_reps  = 8'($urandom_range(3));
            start     = ($urandom_range(7) == 0);
            pause     = ($urandom_range(9) == 0);
            stop      = ($urandom_range(39) == 0);
            step("rand");
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_seq_ctrl.md
# mod_n_seq_ctrl

Run-time controller for the modulo-N counting datapath. It holds a programmable modulus and repeat count, loaded through a valid/ready configuration port. It sequences the counter through start, pause, stop and completion, and exports the live count with per-wrap and end-of-run strobes. It sits between a host/config master and any logic that consumes the MOD-N count.

## Interface
- WIDTH, 4: count and modulus width.
- REPW, 8: repeat-count width.
- DEF_MOD, 10: modulus loaded at reset.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when high with cfg_valid.
- cfg_mod  in  WIDTH  modulus; 0 means 2^WIDTH.
- cfg_reps  in  REPW  number of wraps per run; 0 means continuous.
- start  in  1  run request, level-sampled each edge.
- pause  in  1  level; hold the count while high.
- stop  in  1  abort the run.
- count  out  WIDTH  current count value.
- wrap  out  1  one-cycle strobe, high in the cycle count has just returned to 0.
- done  out  1  one-cycle strobe at the end of a finite run.
- busy  out  1  high in RUN or PAUSE.
- reps_left  out  REPW  wraps remaining in a finite run.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Registers: state, mod_r, reps_r, count, reps_left, wrap, done.
- Reset values: state=IDLE, mod_r=DEF_MOD, reps_r=0, count=0, reps_left=0, wrap=0, done=0, cfg_ready=1, busy=0.
- cfg_ready = (state==IDLE). Config handshake: cfg_valid&&cfg_ready loads mod_r/reps_r. A cfg_valid seen in any other state is stalled: there is no load and no loss, and the master holds the request.
- IDLE: count=0.
  - start -> RUN with count=0 and reps_left=reps (configured value).
  - If cfg and start fire on the same edge, the new config is used.
- RUN: count increments each edge. At count==M-1 (M = mod_r, or 2^WIDTH when mod_r==0) the next value is 0 and wrap=1.
  - The wrap arithmetic is an explicit compare, not natural overflow, except when M=2^WIDTH.
  - M==1: count stays 0 and wrap is high every RUN cycle.
- Finite run (reps_r!=0): each wrap decrements reps_left. The wrap that takes reps_left 1->0 moves the state to DONE instead of staying in RUN.
- Continuous run (reps_r==0): reps_left stays 0 and the run never completes.
- DONE: lasts exactly one cycle with done=1, count=0, wrap=1; then IDLE. start is ignored in DONE.
- PAUSE: entered from RUN while pause=1.
  - count, reps_left and wrap are held, with wrap forced to 0.
  - pause=0 returns to RUN; counting resumes on the next edge.
- Priority in RUN/PAUSE: stop > pause > count. stop -> IDLE with count=0 and reps_left=0, no done and no wrap.
- start in RUN/PAUSE is ignored; it does not restart the count.
- Config changes never affect a run in progress.

## Timing
- All outputs are registered. cfg_ready and busy decode the state register directly.
- start sampled at edge k: from k, busy=1 and count=0; from k+1, count=1.
- Wrap latency: count==M-1 at the state after edge j gives wrap=1 and count=0 after edge j+1.
- Finite run with M, R: the DONE cycle begins at edge k+M*R; IDLE follows at k+M*R+1.
- pause/stop take effect on the edge where they are sampled high. There is no extra pipeline delay.
- rst takes effect on the edge where it is sampled high, overriding all states and handshakes. Outputs take reset values the next cycle.

## Test plan
- Reset/defaults: rst high 2 cycles, then start=1 for 1 cycle -> count cycles 0..9 (DEF_MOD=10), with wrap high whenever count returns to 0. Continuous run, reps_left=0, done never asserts.
- Finite run: cfg_mod=5, cfg_reps=3 loaded, start at edge k -> three 0..4 sequences. Wraps at k+5 and k+10, with reps_left 2 then 1. At k+15: DONE with count=0, wrap=1, done=1, reps_left=0. At k+16: IDLE with busy=0.
- Pause/stop: mod=10, continuous. pause high for 3 cycles at count=4 -> count holds 4, busy=1, no wrap, then resumes at 5. stop at count=7 -> next cycle IDLE, count=0, busy=0, done=0.
- Config handshake: cfg_valid high during RUN -> cfg_ready=0 and mod_r unchanged. After stop, the pending cfg_mod=3 is accepted in IDLE; the next run counts 0,1,2,0.
- Edge moduli: cfg_mod=1 -> count stays 0 with wrap high every RUN cycle. cfg_mod=0 with WIDTH=4 -> count 0..15, wrap on 15->0.
- Reset mid-run: rst at count=6 with reps_left=2 -> next cycle all outputs at reset values and mod_r=DEF_MOD. Same-edge cfg+start in IDLE uses the new modulus.
